// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: selects control bundle or bubble for ID/EX using a
// self-maintained two-slot (EX, MEM) destination scoreboard for hazard detection.
module id_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       IDRegisterRs,
  input  logic [4:0]       IDRegisterRt,
  input  logic [4:0]       IDRegisterRd,
  input  logic             IDMemRead,
  input  logic             IDMemtoReg,
  input  logic             IDMemWrite,
  input  logic             IDALUSrc,
  input  logic             IDRegWrite,
  input  logic             IDRegDst,
  input  logic [2:0]       IDALUOp,
  input  logic             branch_taken,
  output logic             IssMemRead,
  output logic             IssMemtoReg,
  output logic             IssMemWrite,
  output logic             IssALUSrc,
  output logic             IssRegWrite,
  output logic             IssRegDst,
  output logic [2:0]       IssALUOp,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {ST_RUN, ST_STALL} state_e;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       ld;
    logic       wr;
  } slot_t;

  state_e           state_q, state_d;
  slot_t            ex_q, ex_d, mem_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       iss_dst;
  logic             ex_hit, mem_hit, stall, bubble_int;

  assign iss_dst = IDRegDst ? IDRegisterRd : IDRegisterRt;

  // $0 is never a real producer, so a zero destination can never match.
  assign ex_hit  = ex_q.v & ex_q.wr & (ex_q.dst != 5'd0) &
                   ((id_uses_rs & (ex_q.dst == IDRegisterRs)) |
                    (id_uses_rt & (ex_q.dst == IDRegisterRt)));
  assign mem_hit = mem_q.v & mem_q.wr & (mem_q.dst != 5'd0) &
                   ((id_uses_rs & (mem_q.dst == IDRegisterRs)) |
                    (id_uses_rt & (mem_q.dst == IDRegisterRt)));

  assign stall = id_valid & (id_is_branch ? (ex_hit | (mem_hit & mem_q.ld))
                                          : (ex_hit & ex_q.ld));
  assign bubble_int = ~id_valid | stall;

  // NOTE: every output written here gets a default first so no latch is inferred.
  always_comb begin
    IssMemRead  = 1'b0;
    IssMemtoReg = 1'b0;
    IssMemWrite = 1'b0;
    IssALUSrc   = 1'b0;
    IssRegWrite = 1'b0;
    IssRegDst   = 1'b0;
    IssALUOp    = 3'd0;
    bubble      = 1'b1;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    if (rst_n) begin
      bubble     = bubble_int;
      pc_write   = ~stall;
      ifid_write = ~stall;
      ifid_flush = id_valid & id_is_branch & branch_taken & ~stall;
      if (!bubble_int) begin
        IssMemRead  = IDMemRead;
        IssMemtoReg = IDMemtoReg;
        IssMemWrite = IDMemWrite;
        IssALUSrc   = IDALUSrc;
        IssRegWrite = IDRegWrite;
        IssRegDst   = IDRegDst;
        IssALUOp    = IDALUOp;
      end
    end
  end

  always_comb begin
    ex_d.v   = ~bubble_int;
    ex_d.dst = iss_dst;
    ex_d.ld  = IDMemRead & ~bubble_int;
    ex_d.wr  = IDRegWrite & ~bubble_int;
    state_d  = stall ? ST_STALL : ST_RUN;
    cnt_d    = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

  // A stall following a stall can only come from a branch waiting on a load in MEM.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state_q == ST_STALL && stall) |-> id_is_branch);

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- ID-side issue controller. Decides each cycle what the ID stage writes into the ID/EX pipeline register: either the decoded instruction's control bundle or a zeroed bubble.
- Keeps its own two-deep scoreboard of in-flight destinations (EX, MEM) built from what it issued, so it needs no feedback from later stages.
- Detects load-use and ID-resolved-branch hazards, and drives PC/IF-ID write enables and the IF/ID flush.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_is_branch  in  1  ID instruction is beq/bne, resolved in ID
- id_uses_rs  in  1  instruction reads Rs
- id_uses_rt  in  1  instruction reads Rt
- IDRegisterRs  in  5  source register Rs
- IDRegisterRt  in  5  source register Rt
- IDRegisterRd  in  5  destination register Rd
- IDMemRead, IDMemtoReg, IDMemWrite, IDALUSrc, IDRegWrite, IDRegDst  in  1 each  decoded controls
- IDALUOp  in  3  decoded ALU op
- branch_taken  in  1  branch comparator result in ID
- IssMemRead, IssMemtoReg, IssMemWrite, IssALUSrc, IssRegWrite, IssRegDst  out  1 each  controls to ID/EX
- IssALUOp  out  3  ALU op to ID/EX
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID update enable
- ifid_flush  out  1  zero IF/ID on the next edge
- bubble  out  1  current issue is a bubble
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard registers:
  - EX slot: ex_v, ex_dst[4:0], ex_ld, ex_wr.
  - MEM slot: mem_v, mem_dst, mem_ld, mem_wr.
  - FSM state: RUN or STALL.
- Issued destination: iss_dst = IDRegDst ? IDRegisterRd : IDRegisterRt.
- Match condition, per stage S: S_v & S_wr & (S_dst != 0) & ((id_uses_rs & S_dst == Rs) | (id_uses_rt & S_dst == Rt)).
- stall (combinational), evaluated only when id_valid=1:
  - Non-branch: stall when the EX slot matches and ex_ld=1 (load-use, 1 cycle).
  - Branch: stall when the EX slot matches (any write), or when the MEM slot matches and mem_ld=1.
  - A load feeding a branch therefore stalls 2 cycles; an ALU result feeding a branch stalls 1. This falls out of re-evaluating each cycle.
- Output rules:
  - bubble = ~id_valid | stall.
  - When bubble=1, all Iss* outputs are 0; otherwise each Iss* equals its ID* input.
  - pc_write = ifid_write = ~stall.
  - ifid_flush = id_valid & id_is_branch & branch_taken & ~stall. A branch is never flushed while it is stalled.
- Clock edge with rst_n=1:
  - mem_* <= ex_*.
  - ex_v <= ~bubble, ex_dst <= iss_dst, ex_ld <= IDMemRead & ~bubble, ex_wr <= IDRegWrite & ~bubble.
  - state <= stall ? STALL : RUN.
  - stall_cnt increments when stall=1 and saturates at all-ones (no wrap).
- Reset, when rst_n is sampled low on an edge:
  - ex_v, mem_v, ex_ld, ex_wr, mem_ld, mem_wr, ex_dst and mem_dst all become 0.
  - state=RUN, stall_cnt=0.
  - While rst_n=0, outputs are forced: Iss*=0, bubble=1, pc_write=0, ifid_write=0, ifid_flush=0.
  - Reset mid-stall discards the stall; the first cycle after reset re-evaluates against the empty scoreboard.
- Register $0: a destination of 0 never causes a hazard.
- id_valid=0: no stall, bubble issued, pc_write=1.
- Latency: hazard decision and issue are same-cycle combinational; the scoreboard updates on the next edge. No internal pipeline delay.

Test Plan:
- Load-use: lw $2 in ID (IDMemRead=1, IDRegWrite=1, RegDst=0, Rt=2), then add reading Rs=2 -> in the add's first ID cycle: stall=1, bubble=1, Iss*=0, pc_write=0. Next cycle: issue passes, stall_cnt=1.
- Load feeding branch: lw writing $3, then beq reading Rs=3 -> 2 consecutive stall cycles; ifid_flush stays 0 during both. Third cycle: branch_taken=1 gives ifid_flush=1; stall_cnt=2.
- ALU result feeding branch: add writing $4, then beq reading Rt=4 -> exactly 1 stall. A non-branch consumer of $4 -> 0 stalls.
- $0 and unused operands: lw writing $0 followed by a use of $0 -> no stall. lw $5 followed by an instruction with id_uses_rs=0 and Rs=5 -> no stall.
- Reset mid-stall: assert rst_n=0 during the 1st stall cycle of the load-branch case -> next cycle: all outputs at reset values, scoreboard empty. After release, beq issues with no stall.
- Saturation: CNT_W=4, force 20 stall cycles -> stall_cnt holds at 15.
